// File: rtl/mem_arb_pkg.sv
// Shared types and width helpers for the unified memory port arbiter.
// Used by the arbiter top and its grant sub-block.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam int GNT_IF = 0;
  localparam int GNT_LS = 1;

  function automatic int cnt_w(input int lat);
    return $clog2(lat + 1);
  endfunction

  function automatic int starve_w(input int smax);
    return $clog2(smax + 1);
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Fetch vs load/store priority select with a fetch starvation guard.
// Load/store wins unless a waiting fetch has been passed over too often.
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       if_valid,
  input  logic       ls_valid,
  input  logic       if_flush,
  input  logic       window,
  output logic [1:0] grant
);

  localparam int SW = starve_w(STARVE_MAX);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt;
  logic          starved;
  logic          ls_win;
  logic          if_win;

  always_comb begin
    starved = (starve_cnt == SMAX) && if_valid;
    ls_win  = window && ls_valid && !starved;
    if_win  = window && !ls_win && if_valid && !if_flush;
    grant   = '0;
    grant[GNT_IF] = if_win;
    grant[GNT_LS] = ls_win;
  end

  // Counts load/store grants taken while a fetch is waiting.
  always_ff @(posedge clk) begin
    if (reset || !if_valid || if_win) begin
      starve_cnt <= '0;
    end else if (ls_win && starve_cnt != SMAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store ports.
// One transaction in flight; a new one may fire in the response cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  input  logic                if_flush,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_rdata,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic                ls_req_we,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_be,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_resp_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-3:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CW = cnt_w(MEM_LAT);
  localparam logic [CW-1:0] LAT = CW'(MEM_LAT);
  localparam logic [CW-1:0] ONE = CW'(1);

  arb_state_e    state;
  owner_e        owner;
  logic [CW-1:0] cnt;
  logic          squash;
  logic          is_store;
  logic          rst_q;

  logic          live;
  logic          resp_cyc;
  logic          window;
  logic [1:0]    grant;
  logic          fire_if;
  logic          fire_ls;
  logic          fire;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^{if_req_addr[1:0], ls_req_addr[1:0]};

  // Outputs stay quiet in the reset cycle and the one after it.
  assign live     = !reset && !rst_q;
  assign resp_cyc = live && (state == BUSY) && (cnt == LAT);
  assign window   = live && ((state == IDLE) || resp_cyc);

  mem_arb_grant #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .clk      (clk),
    .reset    (reset),
    .if_valid (if_req_valid),
    .ls_valid (ls_req_valid),
    .if_flush (if_flush),
    .window   (window),
    .grant    (grant)
  );

  assign fire_if      = grant[GNT_IF];
  assign fire_ls      = grant[GNT_LS];
  assign fire         = fire_if || fire_ls;
  assign if_req_ready = fire_if;
  assign ls_req_ready = fire_ls;

  always_comb begin
    if_resp_valid = resp_cyc && (owner == OWN_IF) && !squash && !if_flush;
    ls_resp_valid = resp_cyc && (owner == OWN_LS);
    if_resp_rdata = if_resp_valid ? mem_rdata : '0;
    ls_resp_rdata = (ls_resp_valid && !is_store) ? mem_rdata : '0;
  end

  always_comb begin
    mem_en    = fire;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    unique case (1'b1)
      fire_ls: begin
        mem_we    = ls_req_we;
        mem_addr  = ls_req_addr[ADDR_W-1:2];
        mem_wdata = ls_req_wdata;
        mem_be    = ls_req_be;
      end
      fire_if: begin
        mem_addr = if_req_addr[ADDR_W-1:2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    rst_q <= reset;
    if (reset) begin
      state    <= IDLE;
      owner    <= OWN_IF;
      cnt      <= '0;
      squash   <= 1'b0;
      is_store <= 1'b0;
    end else begin
      if (fire) begin
        state    <= BUSY;
        cnt      <= ONE;
        owner    <= fire_ls ? OWN_LS : OWN_IF;
        is_store <= fire_ls && ls_req_we;
      end else if (state == BUSY) begin
        if (cnt == LAT) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + ONE;
        end
      end
      // A redirect kills the in-flight fetch until its slot retires.
      if (resp_cyc) begin
        squash <= 1'b0;
      end else if (if_flush && state == BUSY && owner == OWN_IF) begin
        squash <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural memory.
// Directed scenarios first, then randomized traffic on both ports.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req_valid;
  logic          if_req_ready;
  logic [AW-1:0] if_req_addr;
  logic          if_flush;
  logic          if_resp_valid;
  logic [DW-1:0] if_resp_rdata;
  logic          ls_req_valid;
  logic          ls_req_ready;
  logic [AW-1:0] ls_req_addr;
  logic          ls_req_we;
  logic [DW-1:0] ls_req_wdata;
  logic [3:0]    ls_req_be;
  logic          ls_resp_valid;
  logic [DW-1:0] ls_resp_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-3:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_rdata;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
    .if_req_addr(if_req_addr), .if_flush(if_flush),
    .if_resp_valid(if_resp_valid), .if_resp_rdata(if_resp_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready),
    .ls_req_addr(ls_req_addr), .ls_req_we(ls_req_we),
    .ls_req_wdata(ls_req_wdata), .ls_req_be(ls_req_be),
    .ls_resp_valid(ls_resp_valid), .ls_resp_rdata(ls_resp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_prev = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= reset;
  end

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'h0190_8093;
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Memory device seen by the DUT
  logic [31:0] dev  [0:255];
  logic [31:0] pipe [0:LAT-1];
  logic        dev_init = 1'b0;
  always @(posedge clk) begin
    if (!dev_init) begin
      for (int i = 0; i < 256; i++) dev[i] <= init_word(i);
      dev_init <= 1'b1;
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) dev[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    pipe[0] <= mem_en ? dev[mem_addr[7:0]] : 32'hDEAD_BEEF;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign mem_rdata = pipe[LAT-1];

  // Reference model
  typedef struct {
    logic [31:0] data;
    int          due;
    bit          sq;
  } exp_t;

  logic [31:0] ref_mem [0:255];
  exp_t        if_q[$];
  exp_t        ls_q[$];
  exp_t        e;
  exp_t        t;
  int          last_due = 0;
  int          w = 0;
  bit          log_en = 0;
  bit          glog[$];
  bit          exp_if, exp_ls, win;
  bit          if_pend = 0, ls_pend = 0;
  logic [31:0] if_snap;
  logic [68:0] ls_snap;
  int          idx;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
  end

  // Monitor and scoreboard
  always @(negedge clk) begin
    if (reset || rst_prev) begin
      chk("reset_outputs",
          {if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid,
           mem_en, mem_we, |mem_addr, |mem_wdata, |mem_be,
           |if_resp_rdata, |ls_resp_rdata}, 0);
      if_q.delete();
      ls_q.delete();
      w = 0;
      last_due = 0;
      if_pend = 0;
      ls_pend = 0;
    end else begin
      if (if_pend)
        assert (if_req_valid && if_req_addr == if_snap)
          else $error("fetch request changed while waiting");
      if (ls_pend)
        assert (ls_req_valid && {ls_req_we, ls_req_addr, ls_req_wdata,
                ls_req_be} == ls_snap)
          else $error("load/store request changed while waiting");

      if (if_flush)
        foreach (if_q[i]) if_q[i].sq = 1'b1;

      if (if_q.size() > 0 && if_q[0].due == cyc) begin
        e = if_q.pop_front();
        if (e.sq) chk("if_squashed", if_resp_valid, 0);
        else begin
          chk("if_resp_valid", if_resp_valid, 1);
          chk("if_rdata", if_resp_rdata, e.data);
        end
      end else chk("if_no_resp", if_resp_valid, 0);

      if (ls_q.size() > 0 && ls_q[0].due == cyc) begin
        e = ls_q.pop_front();
        chk("ls_resp_valid", ls_resp_valid, 1);
        chk("ls_rdata", ls_resp_rdata, e.data);
      end else chk("ls_no_resp", ls_resp_valid, 0);

      win    = (cyc >= last_due);
      exp_ls = win && ls_req_valid && !(w == SMAX && if_req_valid);
      exp_if = win && !exp_ls && if_req_valid && !if_flush;
      chk("if_ready", if_req_ready, exp_if);
      chk("ls_ready", ls_req_ready, exp_ls);
      chk("mem_en", mem_en, exp_if || exp_ls);

      if (exp_ls) begin
        idx = int'(ls_req_addr[9:2]);
        chk("ls_mem_addr", mem_addr, ls_req_addr[31:2]);
        chk("ls_mem_we", mem_we, ls_req_we);
        t.due = cyc + LAT;
        t.sq  = 1'b0;
        if (ls_req_we) begin
          chk("mem_wdata", mem_wdata, ls_req_wdata);
          chk("mem_be", mem_be, ls_req_be);
          for (int b = 0; b < 4; b++)
            if (ls_req_be[b]) ref_mem[idx][8*b +: 8] = ls_req_wdata[8*b +: 8];
          t.data = 32'h0;
        end else begin
          t.data = ref_mem[idx];
        end
        ls_q.push_back(t);
        last_due = cyc + LAT;
      end
      if (exp_if) begin
        idx = int'(if_req_addr[9:2]);
        chk("if_mem_addr", mem_addr, if_req_addr[31:2]);
        chk("if_mem_we_be", {mem_we, mem_be}, 0);
        t.data = ref_mem[idx];
        t.due  = cyc + LAT;
        t.sq   = 1'b0;
        if_q.push_back(t);
        last_due = cyc + LAT;
      end

      if (!if_req_valid || exp_if) w = 0;
      else if (exp_ls && w < SMAX) w++;

      if (log_en && mem_en) glog.push_back(if_req_ready);

      if_pend = if_req_valid && !if_req_ready;
      ls_pend = ls_req_valid && !ls_req_ready;
      if_snap = if_req_addr;
      ls_snap = {ls_req_we, ls_req_addr, ls_req_wdata, ls_req_be};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit ls, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    bit f = 0;
    if (ls) begin
      ls_req_valid = 1; ls_req_we = we; ls_req_addr = a;
      ls_req_wdata = wd; ls_req_be = be;
    end else begin
      if_req_valid = 1; if_req_addr = a;
    end
    for (int i = 0; i < 20 && !f; i++) begin
      @(negedge clk);
      f = ls ? ls_req_ready : if_req_ready;
      tick();
    end
    chk("fire_timeout", f, 1);
    if (ls) ls_req_valid = 0;
    else if_req_valid = 0;
  endtask

  task automatic drain();
    int i = 0;
    bit fi, fl;
    while ((if_req_valid || ls_req_valid) && i < 40) begin
      @(negedge clk);
      fi = if_req_valid && if_req_ready;
      fl = ls_req_valid && ls_req_ready;
      tick();
      if (fi) if_req_valid = 0;
      if (fl) ls_req_valid = 0;
      i++;
    end
    chk("drain_timeout", {if_req_valid, ls_req_valid}, 0);
    if_req_valid = 0;
    ls_req_valid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc[$];
    int k;
    bit fi, fl;
    reset = 1; if_flush = 0;
    if_req_valid = 0; if_req_addr = 0;
    ls_req_valid = 0; ls_req_addr = 0; ls_req_we = 0;
    ls_req_wdata = 0; ls_req_be = 0;
    tick(); tick();
    reset = 0;

    // First fetch straight out of reset
    issue(0, 0, 32'h0, 0, 0);
    repeat (3) tick();

    // Store then load back
    issue(1, 1, 32'h64, 32'h4B, 4'hF);
    issue(1, 0, 32'h64, 0, 0);
    repeat (3) tick();

    // Both ports valid continuously
    glog.delete();
    log_en = 1;
    if_req_valid = 1; if_req_addr = 32'h10;
    ls_req_valid = 1; ls_req_we = 0; ls_req_addr = 32'h20;
    repeat (12) tick();
    log_en = 0;
    drain();
    chk("grant_count", glog.size(), 6);
    foreach (glog[i]) chk("grant_pattern", glog[i], (i % 5) == 4);
    repeat (2) tick();

    // Flush an in-flight fetch, then fetch again
    issue(0, 0, 32'h30, 0, 0);
    if_flush = 1;
    tick();
    if_flush = 0;
    issue(0, 0, 32'hE8, 0, 0);
    repeat (3) tick();

    // Reset during a load, with both ports requesting
    issue(1, 0, 32'h64, 0, 0);
    reset = 1;
    if_req_valid = 1; if_req_addr = 32'h4;
    ls_req_valid = 1; ls_req_we = 0; ls_req_addr = 32'h64;
    tick();
    reset = 0;
    tick();
    drain();
    repeat (3) tick();

    // Back-to-back loads held valid
    k = 0;
    ls_req_valid = 1; ls_req_we = 0; ls_req_addr = 32'h0;
    for (int i = 0; i < 30 && k < 3; i++) begin
      @(negedge clk);
      if (ls_req_ready) begin
        fc.push_back(cyc);
        k++;
      end
      tick();
      if (k < 3) ls_req_addr = 32'(k * 4);
      else ls_req_valid = 0;
    end
    ls_req_valid = 0;
    chk("burst_count", fc.size(), 3);
    for (int i = 1; i < fc.size(); i++)
      chk("burst_gap", fc[i] - fc[i-1], 2);
    repeat (3) tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      fi = if_req_valid && if_req_ready;
      fl = ls_req_valid && ls_req_ready;
      tick();
      if (!if_req_valid || fi) begin
        if_req_valid = ($urandom_range(0, 2) != 0);
        if_req_addr  = $urandom;
      end
      if (!ls_req_valid || fl) begin
        ls_req_valid = 1'($urandom_range(0, 1));
        ls_req_we    = 1'($urandom_range(0, 1));
        ls_req_addr  = $urandom;
        ls_req_wdata = $urandom;
        ls_req_be    = 4'($urandom_range(0, 15));
      end
      if_flush = ($urandom_range(0, 9) == 0);
    end
    if_flush = 0;
    drain();
    repeat (4) tick();
    chk("if_queue_empty", if_q.size(), 0);
    chk("ls_queue_empty", ls_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
